// File: rtl/ariane_pkg.sv
// Shared frontend constants and the compressed-instruction predicate used by
// both the realigner and the decoder.
package ariane_pkg;

   localparam int unsigned FETCH_WIDTH     = 32;
   localparam int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16;

   function automatic logic is_compressed(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/realign_scan.sv
// Combinational halfword scanner: turns one fetch block (plus an optional held
// lower half) into compacted instruction slots and a possible carry-out half.
module realign_scan
   import ariane_pkg::*;
#(
   parameter int unsigned NumSlots = INSTR_PER_FETCH,
   parameter int unsigned SlotW    = 1
) (
   input  logic [NumSlots-1:0][15:0] hw_i,
   input  logic [63:0]               base_i,
   input  logic [SlotW-1:0]          start_i,
   input  logic                      cont_i,
   input  logic [15:0]               held_instr_i,
   input  logic [63:0]               held_addr_i,
   output logic [NumSlots-1:0]       valid_o,
   output logic [NumSlots-1:0][31:0] instr_o,
   output logic [NumSlots-1:0][63:0] addr_o,
   output logic                      serving_o,
   output logic                      carry_o,
   output logic [15:0]               carry_instr_o,
   output logic [63:0]               carry_addr_o
);

   always_comb begin
      int   j;
      logic skip;
      logic active;
      valid_o       = '0;
      instr_o       = '0;
      addr_o        = '0;
      serving_o     = 1'b0;
      carry_o       = 1'b0;
      carry_instr_o = '0;
      carry_addr_o  = '0;
      j             = 0;
      skip          = 1'b0;
      active        = 1'b0;

      if (cont_i) begin
         valid_o[0] = 1'b1;
         instr_o[0] = {hw_i[0], held_instr_i};
         addr_o[0]  = held_addr_i;
         serving_o  = 1'b1;
         j          = 1;
      end

      for (int k = 0; k < NumSlots; k++) begin
         // halfword 0 is already consumed by a continuation
         active = cont_i ? (k != 0) : (k >= int'(start_i));
         if (skip) begin
            skip = 1'b0;
         end else if (active) begin
            if (is_compressed(hw_i[k])) begin
               for (int m = 0; m < NumSlots; m++) begin
                  if (m == j) begin
                     valid_o[m] = 1'b1;
                     instr_o[m] = {16'b0, hw_i[k]};
                     addr_o[m]  = base_i + 64'(2 * k);
                  end
               end
               j++;
            end else if (k < NumSlots - 1) begin
               for (int m = 0; m < NumSlots; m++) begin
                  if (m == j) begin
                     valid_o[m] = 1'b1;
                     instr_o[m] = {hw_i[(k + 1) % NumSlots], hw_i[k]};
                     addr_o[m]  = base_i + 64'(2 * k);
                  end
               end
               j++;
               skip = 1'b1;
            end else begin
               carry_o       = 1'b1;
               carry_instr_o = hw_i[k];
               carry_addr_o  = base_i + 64'(2 * k);
            end
         end
      end
   end

endmodule

// File: rtl/instr_realigner.sv
// Fetch-block realigner: splits I$ blocks into compacted 16/32-bit instructions
// and carries the lower half of a block-straddling instruction forward.
module instr_realigner #(
   parameter int unsigned FETCH_WIDTH = ariane_pkg::FETCH_WIDTH
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,
   input  logic                              valid_i,
   input  logic [FETCH_WIDTH-1:0]            data_i,
   input  logic [63:0]                       address_i,
   input  logic                              exception_i,
   output logic [FETCH_WIDTH/16-1:0]         valid_o,
   output logic [FETCH_WIDTH/16-1:0][31:0]   instr_o,
   output logic [FETCH_WIDTH/16-1:0][63:0]   addr_o,
   output logic                              ex_o,
   output logic                              serving_unaligned_o
);

   localparam int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16;
   localparam int unsigned OffW            = $clog2(FETCH_WIDTH / 8);
   localparam int unsigned SlotW           = OffW - 1;

   logic                              unaligned_q, unaligned_d;
   logic [15:0]                       unaligned_instr_q, unaligned_instr_d;
   logic [63:0]                       unaligned_addr_q, unaligned_addr_d;

   logic [INSTR_PER_FETCH-1:0][15:0]  hw;
   logic [63:0]                       base;
   logic [SlotW-1:0]                  start;
   logic                              cont;
   logic [INSTR_PER_FETCH-1:0]        scan_valid;
   logic [INSTR_PER_FETCH-1:0][31:0]  scan_instr;
   logic [INSTR_PER_FETCH-1:0][63:0]  scan_addr;
   logic                              scan_serving;
   logic                              scan_carry;
   logic [15:0]                       scan_carry_instr;
   logic [63:0]                       scan_carry_addr;

   assign hw    = data_i;
   assign base  = {address_i[63:OffW], {OffW{1'b0}}};
   assign start = address_i[OffW-1:1];
   // any other address while holding a half is a silent redirect
   assign cont  = unaligned_q && (start == '0) && (address_i == unaligned_addr_q + 64'd2);

   realign_scan #(
      .NumSlots (INSTR_PER_FETCH),
      .SlotW    (SlotW)
   ) u_scan (
      .hw_i          (hw),
      .base_i        (base),
      .start_i       (start),
      .cont_i        (cont),
      .held_instr_i  (unaligned_instr_q),
      .held_addr_i   (unaligned_addr_q),
      .valid_o       (scan_valid),
      .instr_o       (scan_instr),
      .addr_o        (scan_addr),
      .serving_o     (scan_serving),
      .carry_o       (scan_carry),
      .carry_instr_o (scan_carry_instr),
      .carry_addr_o  (scan_carry_addr)
   );

   always_comb begin
      valid_o             = '0;
      instr_o             = '0;
      addr_o              = '0;
      ex_o                = 1'b0;
      serving_unaligned_o = 1'b0;
      unaligned_d         = unaligned_q;
      unaligned_instr_d   = unaligned_instr_q;
      unaligned_addr_d    = unaligned_addr_q;

      if (!rst_i && valid_i) begin
         if (exception_i) begin
            valid_o[0]  = 1'b1;
            ex_o        = 1'b1;
            // a fault while holding a half belongs to the straddling instruction
            addr_o[0]   = unaligned_q ? unaligned_addr_q : address_i;
            unaligned_d = 1'b0;
         end else begin
            valid_o             = scan_valid;
            instr_o             = scan_instr;
            addr_o              = scan_addr;
            serving_unaligned_o = scan_serving;
            unaligned_d         = scan_carry;
            if (scan_carry) begin
               unaligned_instr_d = scan_carry_instr;
               unaligned_addr_d  = scan_carry_addr;
            end
         end
      end

      if (flush_i) begin
         unaligned_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         unaligned_q       <= 1'b0;
         unaligned_instr_q <= '0;
         unaligned_addr_q  <= '0;
      end else begin
         unaligned_q       <= unaligned_d;
         unaligned_instr_q <= unaligned_instr_d;
         unaligned_addr_q  <= unaligned_addr_d;
      end
   end

endmodule

// File: tb/tb_instr_realigner.sv
// Directed bench for instr_realigner at FETCH_WIDTH=32.
module tb_instr_realigner;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             flush_i;
   logic             valid_i;
   logic [31:0]      data_i;
   logic [63:0]      address_i;
   logic             exception_i;
   logic [1:0]       valid_o;
   logic [1:0][31:0] instr_o;
   logic [1:0][63:0] addr_o;
   logic             ex_o;
   logic             serving_unaligned_o;

   int checks   = 0;
   int failures = 0;

   instr_realigner #(
      .FETCH_WIDTH (32)
   ) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .flush_i             (flush_i),
      .valid_i             (valid_i),
      .data_i              (data_i),
      .address_i           (address_i),
      .exception_i         (exception_i),
      .valid_o             (valid_o),
      .instr_o             (instr_o),
      .addr_o              (addr_o),
      .ex_o                (ex_o),
      .serving_unaligned_o (serving_unaligned_o)
   );

   always #5 clk_i = ~clk_i;

   // Drive at the falling edge; outputs are sampled 2 time units later.
   task automatic apply(input logic v, input logic ex, input logic fl,
                        input logic [63:0] a, input logic [31:0] d);
      @(negedge clk_i);
      valid_i     = v;
      exception_i = ex;
      flush_i     = fl;
      address_i   = a;
      data_i      = d;
      #2;
   endtask

   task automatic do_straddle();
      apply(1'b1, 1'b0, 1'b0, 64'h1000, 32'h0013_4581);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      valid_i = 1'b1; exception_i = 1'b1; flush_i = 1'b0;
      address_i = 64'h1000; data_i = 32'h4501_4581;
      #3;
      checks++;
      if (valid_o !== 2'b00) begin
         failures++; $display("FAIL reset_valid got=%b exp=00", valid_o);
      end
      checks++;
      if (ex_o !== 1'b0 || serving_unaligned_o !== 1'b0) begin
         failures++; $display("FAIL reset_flags got ex=%b srv=%b exp=0/0", ex_o, serving_unaligned_o);
      end
      checks++;
      if (instr_o !== '0 || addr_o !== '0) begin
         failures++; $display("FAIL reset_data got i=%h a=%h exp=0", instr_o, addr_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      valid_i = 1'b0; exception_i = 1'b0;
   endtask

   task automatic test_two_compressed();
      apply(1'b1, 1'b0, 1'b0, 64'h1000, 32'h4501_4581);
      checks++;
      if (valid_o !== 2'b11) begin
         failures++; $display("FAIL twoc_valid got=%b exp=11", valid_o);
      end
      checks++;
      if (instr_o[0] !== 32'h0000_4581 || addr_o[0] !== 64'h1000) begin
         failures++; $display("FAIL twoc_slot0 got=%h@%h exp=00004581@1000", instr_o[0], addr_o[0]);
      end
      checks++;
      if (instr_o[1] !== 32'h0000_4501 || addr_o[1] !== 64'h1002) begin
         failures++; $display("FAIL twoc_slot1 got=%h@%h exp=00004501@1002", instr_o[1], addr_o[1]);
      end
      @(posedge clk_i); #1;
      checks++;
      if (dut.unaligned_q !== 1'b0) begin
         failures++; $display("FAIL twoc_unaligned got=%b exp=0", dut.unaligned_q);
      end
   endtask

   task automatic test_single_32();
      apply(1'b1, 1'b0, 1'b0, 64'h1000, 32'h0000_0013);
      checks++;
      if (valid_o !== 2'b01 || instr_o[0] !== 32'h0000_0013 || addr_o[0] !== 64'h1000) begin
         failures++;
         $display("FAIL single32 got v=%b %h@%h exp v=01 00000013@1000", valid_o, instr_o[0], addr_o[0]);
      end
   endtask

   task automatic test_straddle();
      do_straddle();
      checks++;
      if (valid_o !== 2'b01 || instr_o[0] !== 32'h0000_4581 || serving_unaligned_o !== 1'b0) begin
         failures++;
         $display("FAIL strad_c1 got v=%b i=%h srv=%b exp v=01 i=00004581 srv=0",
                  valid_o, instr_o[0], serving_unaligned_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (dut.unaligned_q !== 1'b1 || dut.unaligned_instr_q !== 16'h0013 ||
          dut.unaligned_addr_q !== 64'h1002) begin
         failures++;
         $display("FAIL strad_held got q=%b h=%h a=%h exp 1 0013 1002",
                  dut.unaligned_q, dut.unaligned_instr_q, dut.unaligned_addr_q);
      end
      apply(1'b1, 1'b0, 1'b0, 64'h1004, 32'h4501_0000);
      checks++;
      if (serving_unaligned_o !== 1'b1 || valid_o !== 2'b11) begin
         failures++; $display("FAIL strad_c2_flags got srv=%b v=%b exp 1 11", serving_unaligned_o, valid_o);
      end
      checks++;
      if (instr_o[0] !== 32'h0000_0013 || addr_o[0] !== 64'h1002) begin
         failures++; $display("FAIL strad_c2_slot0 got=%h@%h exp=00000013@1002", instr_o[0], addr_o[0]);
      end
      checks++;
      if (instr_o[1] !== 32'h0000_4501 || addr_o[1] !== 64'h1006) begin
         failures++; $display("FAIL strad_c2_slot1 got=%h@%h exp=00004501@1006", instr_o[1], addr_o[1]);
      end
   endtask

   task automatic test_redirect_start();
      apply(1'b1, 1'b0, 1'b0, 64'h2002, 32'h4581_ABCD);
      checks++;
      if (valid_o !== 2'b01 || instr_o[0] !== 32'h0000_4581 || addr_o[0] !== 64'h2002) begin
         failures++;
         $display("FAIL redirect got v=%b %h@%h exp v=01 00004581@2002", valid_o, instr_o[0], addr_o[0]);
      end
      // held half dropped when the next block is not contiguous
      do_straddle();
      apply(1'b1, 1'b0, 1'b0, 64'h3000, 32'h4501_0000);
      checks++;
      if (serving_unaligned_o !== 1'b0 || instr_o[0] !== 32'h0 || addr_o[0] !== 64'h3000 ||
          instr_o[1] !== 32'h0000_4501 || addr_o[1] !== 64'h3002) begin
         failures++;
         $display("FAIL redirect_drop got srv=%b %h@%h %h@%h exp 0 0@3000 4501@3002",
                  serving_unaligned_o, instr_o[0], addr_o[0], instr_o[1], addr_o[1]);
      end
   endtask

   task automatic test_flush();
      do_straddle();
      apply(1'b0, 1'b0, 1'b1, 64'h0, 32'h0);
      apply(1'b1, 1'b0, 1'b0, 64'h1004, 32'h4501_0000);
      checks++;
      if (serving_unaligned_o !== 1'b0 || instr_o[0] !== 32'h0 || addr_o[0] !== 64'h1004) begin
         failures++;
         $display("FAIL flush got srv=%b %h@%h exp 0 00000000@1004", serving_unaligned_o, instr_o[0], addr_o[0]);
      end
      // flush on the capture cycle itself
      apply(1'b1, 1'b0, 1'b1, 64'h1000, 32'h0013_4581);
      checks++;
      if (valid_o !== 2'b01 || instr_o[0] !== 32'h0000_4581) begin
         failures++; $display("FAIL flush_cap_out got v=%b i=%h exp 01 00004581", valid_o, instr_o[0]);
      end
      apply(1'b1, 1'b0, 1'b0, 64'h1004, 32'h4501_0000);
      checks++;
      if (serving_unaligned_o !== 1'b0) begin
         failures++; $display("FAIL flush_cap_srv got=%b exp=0", serving_unaligned_o);
      end
   endtask

   task automatic test_reset_mid();
      do_straddle();
      apply(1'b1, 1'b0, 1'b0, 64'h1004, 32'h4501_0000);
      checks++;
      if (serving_unaligned_o !== 1'b1) begin
         failures++; $display("FAIL rstmid_pre got srv=%b exp=1", serving_unaligned_o);
      end
      #1 rst_i = 1'b1;
      #1;
      checks++;
      if (valid_o !== 2'b00 || serving_unaligned_o !== 1'b0) begin
         failures++; $display("FAIL rstmid_async got v=%b srv=%b exp 00 0", valid_o, serving_unaligned_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      apply(1'b1, 1'b0, 1'b0, 64'h1004, 32'h4501_0000);
      checks++;
      if (serving_unaligned_o !== 1'b0 || addr_o[0] !== 64'h1004) begin
         failures++; $display("FAIL rstmid_after got srv=%b a=%h exp 0 1004", serving_unaligned_o, addr_o[0]);
      end
   endtask

   task automatic test_valid_low();
      do_straddle();
      apply(1'b0, 1'b0, 1'b0, 64'h1004, 32'h4501_0000);
      checks++;
      if (valid_o !== 2'b00 || serving_unaligned_o !== 1'b0 || ex_o !== 1'b0) begin
         failures++;
         $display("FAIL vlow_out got v=%b srv=%b ex=%b exp 00 0 0", valid_o, serving_unaligned_o, ex_o);
      end
      apply(1'b1, 1'b0, 1'b0, 64'h1004, 32'h4501_0000);
      checks++;
      if (serving_unaligned_o !== 1'b1 || addr_o[0] !== 64'h1002) begin
         failures++; $display("FAIL vlow_hold got srv=%b a=%h exp 1 1002", serving_unaligned_o, addr_o[0]);
      end
   endtask

   task automatic test_exception();
      do_straddle();
      apply(1'b1, 1'b1, 1'b0, 64'h1004, 32'h4501_0000);
      checks++;
      if (ex_o !== 1'b1 || valid_o !== 2'b01 || serving_unaligned_o !== 1'b0) begin
         failures++;
         $display("FAIL exc_flags got ex=%b v=%b srv=%b exp 1 01 0", ex_o, valid_o, serving_unaligned_o);
      end
      checks++;
      if (instr_o[0] !== 32'h0 || addr_o[0] !== 64'h1002) begin
         failures++; $display("FAIL exc_slot0 got=%h@%h exp=00000000@1002", instr_o[0], addr_o[0]);
      end
      @(posedge clk_i); #1;
      checks++;
      if (dut.unaligned_q !== 1'b0) begin
         failures++; $display("FAIL exc_clear got=%b exp=0", dut.unaligned_q);
      end
      apply(1'b1, 1'b1, 1'b0, 64'h2002, 32'h4581_4581);
      checks++;
      if (ex_o !== 1'b1 || valid_o !== 2'b01 || addr_o[0] !== 64'h2002) begin
         failures++; $display("FAIL exc_fresh got ex=%b v=%b a=%h exp 1 01 2002", ex_o, valid_o, addr_o[0]);
      end
   endtask

   initial begin
      test_reset();
      test_two_compressed();
      test_single_32();
      test_straddle();
      test_redirect_start();
      test_flush();
      test_reset_mid();
      test_valid_low();
      test_exception();
      @(negedge clk_i);
      valid_i = 1'b0; exception_i = 1'b0; flush_i = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
